pedal_ctrl: RTL and testbench
=============================

Name: pedal_ctrl

Overview:
Footswitch control front-end that produces the en[3:0] and options[3:0] control words consumed by the effect blocks (octaver, etc.).
- Debounces four raw footswitches.
- Short press toggles the effect enable; long press toggles the effect option bit.
- Runs entirely in the clk_48 sample-clock domain. Outputs are registered and stable between events.

Parameters:
N_FX, 4, number of footswitches / effect slots (en and options width)
DEBOUNCE_SAMPLES, 480, consecutive stable samples required to accept a switch level change (10 ms)
LONG_PRESS_SAMPLES, 38400, debounced hold length that classifies a press as long (0.8 s)

Ports:
clk_48  in  1  48 kHz sample clock, sole clock
rst_n  in  1  asynchronous active-low reset
fsw_n  in  N_FX  raw footswitch inputs, active-low, asynchronous, bouncy
en  out  N_FX  effect enables; bit i enables effect slot i (bit 2 = octaver)
options  out  N_FX  effect option bits; bit i toggled by long press on switch i
led  out  N_FX  status LEDs; equals en
evt  out  1  one-cycle pulse in the cycle en or options changes

Behaviour:
- Reset (async assert, sync deassert internal to clk_48): en=0, options=0, led=0, evt=0. All counters are 0, all press FSMs are IDLE, debounced state = released.
- Sync: each fsw_n bit passes through a 2-flop synchronizer. Pressed = synchronized level low.
- Debounce:
  - Per switch, the counter increments while the synced level differs from the debounced level, and clears when they match.
  - When the counter reaches DEBOUNCE_SAMPLES-1, the debounced level flips and the counter clears.
  - A glitch shorter than DEBOUNCE_SAMPLES never changes the debounced level.
- Press FSM, per switch:
  - IDLE: on debounced press -> HOLD; hold counter=0.
  - HOLD: hold counter increments, saturating at LONG_PRESS_SAMPLES.
    - On debounced release with count < LONG_PRESS_SAMPLES-1: short event -> IDLE.
    - On count reaching LONG_PRESS_SAMPLES-1 while still pressed: long event -> LATCHED.
  - LATCHED: no further events; on debounced release -> IDLE.
- Actions, applied one cycle after the event (registered):
  - Short on switch i: en[i] <= ~en[i].
  - Long on switch i: options[i] <= ~options[i]. en is unchanged.
  - evt=1 in the same cycle the registers update, otherwise 0.
- Simultaneous events on different switches in one cycle: all are applied in that cycle with a single evt pulse. Never serialized or dropped.
- Panic:
  - If all N_FX debounced levels are pressed simultaneously: en=0, options=0, evt=1 (once).
  - All press FSMs go to LATCHED, so no short/long events fire until each switch is released.
  - Panic has priority over any event in the same cycle.
- Latency:
  - Short press: 2 sync + DEBOUNCE_SAMPLES (release) + 1 register cycles after release settles.
  - Long press: 2 + DEBOUNCE_SAMPLES + LONG_PRESS_SAMPLES + 1 cycles after press settles.
- Reset mid-press: state is discarded. After reset, a switch still held is seen as a new press once debounced.

Optional Feature:
PEDAL_CTRL_EXCLUSIVE_FX_EN
- Defined: a short press that sets en[i]=1 clears all other en bits in the same cycle (en stays one-hot or zero). Toggling off the active slot leaves en=0. When simultaneous shorts would set multiple bits, the lowest index wins.
- Undefined: en bits toggle independently.

Decomposition:
- Package pedal_ctrl_pkg:
  - press_state_t enum {IDLE, HOLD, LATCHED}
  - default constants N_FX=4, DEBOUNCE_SAMPLES=480, LONG_PRESS_SAMPLES=38400
  - counter width derived via $clog2 of the largest count
- Sub-module fsw_debounce: one per switch (sync + debounce + press FSM), outputs pressed_db, short_evt, long_evt. It also takes a force_latch input used by panic.
- pedal_ctrl holds the en/options registers, panic detect and the exclusive logic.

Test Plan:
All scenarios use bench parameters DEBOUNCE_SAMPLES=4, LONG_PRESS_SAMPLES=20.
- Reset: hold rst_n=0 with fsw_n=4'b1011, release -> en=0, options=0, evt=0 until the press is debounced and released.
- Short press: fsw_n[2] low 10 cycles then high -> en=4'b0100, led=4'b0100, single evt pulse. Repeat -> en=0.
- Bounce: fsw_n[0] toggles every 2 cycles for 40 cycles, then high -> en, options and evt unchanged.
- Long press: fsw_n[3] low 40 cycles -> options=4'b1000 at hold count 19 with one evt. Release -> no en change.
- Simultaneous and panic: shorts on switches 0 and 1 released in the same cycle -> en=4'b0011, one evt. Then all four held 10 cycles -> en=0, options=0, one evt, no events on release.
- PEDAL_CTRL_EXCLUSIVE_FX_EN defined: short on 1 then short on 2 -> en=4'b0010 then en=4'b0100.

Source files
------------

// File: rtl/pedal_ctrl_pkg.sv
// Shared types and default sizing for the footswitch controller (PEDAL_CTRL_EXCLUSIVE_FX_EN lives in the top).
// Definitions only: no latency, no flow control.
package pedal_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    LATCHED
  } press_state_t;

  localparam int DEF_N_FX               = 4;
  localparam int DEF_DEBOUNCE_SAMPLES   = 480;
  localparam int DEF_LONG_PRESS_SAMPLES = 38400;

  function automatic int cnt_width(input int max_count);
    return (max_count < 2) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/pedal_ctrl_fsw_debounce.sv
// One footswitch: 2-flop sync, debounce, short/long press classifier; events 2+DEBOUNCE after the raw edge.
// No backpressure: events are single-cycle pulses; force_latch suppresses them until release.
module pedal_ctrl_fsw_debounce
  import pedal_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_SAMPLES   = DEF_DEBOUNCE_SAMPLES,
  parameter int LONG_PRESS_SAMPLES = DEF_LONG_PRESS_SAMPLES
) (
  input  logic clk_48,
  input  logic rst_n,
  input  logic fsw_n,
  input  logic force_latch,
  output logic pressed_db,
  output logic short_evt,
  output logic long_evt
);

  localparam int DW = cnt_width(DEBOUNCE_SAMPLES - 1);
  localparam int HW = cnt_width(LONG_PRESS_SAMPLES);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_SAMPLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_SAMPLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_SAMPLES - 1);

  logic [1:0]    r_sync;
  logic          r_db;
  logic [DW-1:0] r_db_cnt;
  logic [HW-1:0] r_hold_cnt;
  logic [HW-1:0] w_hold_nxt;
  logic          w_sync_pressed;
  press_state_t  r_state;
  press_state_t  w_state_nxt;

  // Sync flops reset to the released (high) level so reset never looks like a press.
  always_ff @(posedge clk_48 or negedge rst_n) begin
    if (!rst_n) r_sync <= 2'b11;
    else        r_sync <= {r_sync[0], fsw_n};
  end

  assign w_sync_pressed = ~r_sync[1];

  always_ff @(posedge clk_48 or negedge rst_n) begin
    if (!rst_n) begin
      r_db     <= 1'b0;
      r_db_cnt <= '0;
    end else if (w_sync_pressed != r_db) begin
      if (r_db_cnt == DB_LAST) begin
        r_db     <= ~r_db;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DW'(1);
      end
    end else begin
      r_db_cnt <= '0;
    end
  end

  always_ff @(posedge clk_48 or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    short_evt   = 1'b0;
    long_evt    = 1'b0;
    if (force_latch) begin
      w_state_nxt = LATCHED;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_db) begin
            w_state_nxt = HOLD;
            w_hold_nxt  = '0;
          end
        end
        HOLD: begin
          if (!r_db) begin
            short_evt   = (r_hold_cnt < HOLD_LAST);
            w_state_nxt = IDLE;
          end else if (r_hold_cnt == HOLD_LAST) begin
            long_evt    = 1'b1;
            w_state_nxt = LATCHED;
          end else if (r_hold_cnt != HOLD_MAX) begin
            w_hold_nxt = r_hold_cnt + HW'(1);
          end
        end
        LATCHED: begin
          if (!r_db) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign pressed_db = r_db;

endmodule

// File: rtl/pedal_ctrl.sv
// Footswitch front-end: en/options toggled by short/long presses, one register stage after each event.
// No backpressure; PEDAL_CTRL_EXCLUSIVE_FX_EN makes en one-hot-or-zero.
module pedal_ctrl
  import pedal_ctrl_pkg::*;
#(
  parameter int N_FX               = DEF_N_FX,
  parameter int DEBOUNCE_SAMPLES   = DEF_DEBOUNCE_SAMPLES,
  parameter int LONG_PRESS_SAMPLES = DEF_LONG_PRESS_SAMPLES
) (
  input  logic            clk_48,
  input  logic            rst_n,
  input  logic [N_FX-1:0] fsw_n,
  output logic [N_FX-1:0] en,
  output logic [N_FX-1:0] options,
  output logic [N_FX-1:0] led,
  output logic            evt
);

  logic [1:0]      r_rst_sync;
  logic            w_rst_n;
  logic [N_FX-1:0] w_pressed;
  logic [N_FX-1:0] w_short;
  logic [N_FX-1:0] w_long;
  logic [N_FX-1:0] w_en_nxt;
  logic            w_all_pressed;
  logic            w_panic;
  logic            r_all_prev;
  logic [N_FX-1:0] r_en;
  logic [N_FX-1:0] r_opt;
  logic            r_evt;

  // Reset asserts immediately, releases two clk_48 edges later.
  always_ff @(posedge clk_48 or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  for (genvar gi = 0; gi < N_FX; gi++) begin : g_fsw
    pedal_ctrl_fsw_debounce #(
      .DEBOUNCE_SAMPLES  (DEBOUNCE_SAMPLES),
      .LONG_PRESS_SAMPLES(LONG_PRESS_SAMPLES)
    ) u_fsw (
      .clk_48     (clk_48),
      .rst_n      (w_rst_n),
      .fsw_n      (fsw_n[gi]),
      .force_latch(w_all_pressed),
      .pressed_db (w_pressed[gi]),
      .short_evt  (w_short[gi]),
      .long_evt   (w_long[gi])
    );
  end

  assign w_all_pressed = &w_pressed;
  assign w_panic       = w_all_pressed & ~r_all_prev;

`ifdef PEDAL_CTRL_EXCLUSIVE_FX_EN
  logic [N_FX-1:0] w_set;
  // A slot being switched on wins over everything; ties go to the lowest index.
  always_comb begin
    w_set    = w_short & ~r_en;
    w_en_nxt = r_en & ~w_short;
    if (|w_set) w_en_nxt = w_set & (~w_set + N_FX'(1));
  end
`else
  always_comb begin
    w_en_nxt = r_en ^ w_short;
  end
`endif

  always_ff @(posedge clk_48 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_all_prev <= 1'b0;
      r_en       <= '0;
      r_opt      <= '0;
      r_evt      <= 1'b0;
    end else begin
      r_all_prev <= w_all_pressed;
      if (w_panic) begin
        r_en  <= '0;
        r_opt <= '0;
        r_evt <= 1'b1;
      end else begin
        r_en  <= w_en_nxt;
        r_opt <= r_opt ^ w_long;
        r_evt <= |{w_short, w_long};
      end
    end
  end

  assign en      = r_en;
  assign led     = r_en;
  assign options = r_opt;
  assign evt     = r_evt;

endmodule

// File: tb/tb_pedal_ctrl.sv
// Bench for pedal_ctrl with DEBOUNCE_SAMPLES=4, LONG_PRESS_SAMPLES=20: directed scenarios plus a
// randomized run compared cycle-by-cycle against a behavioural press/hold model.
module tb_pedal_ctrl;

  localparam int D = 4;
  localparam int L = 20;

  logic       clk_48;
  logic       rst_n;
  logic [3:0] fsw_n;
  logic [3:0] en;
  logic [3:0] options;
  logic [3:0] led;
  logic       evt;

  int errors = 0;
  int checks = 0;

  initial clk_48 = 1'b0;
  always #5 clk_48 = ~clk_48;

  pedal_ctrl #(
    .N_FX(4),
    .DEBOUNCE_SAMPLES(D),
    .LONG_PRESS_SAMPLES(L)
  ) dut (
    .clk_48 (clk_48),
    .rst_n  (rst_n),
    .fsw_n  (fsw_n),
    .en     (en),
    .options(options),
    .led    (led),
    .evt    (evt)
  );

  // Reference model: debounced level = last D synced samples agree; a press is described by how
  // many cycles it has been debounced-pressed and whether it already produced its event.
  logic [3:0]   m_s1, m_s2, m_db, m_done, m_en, m_opt;
  logic         m_evt, m_all_prev;
  logic [D-1:0] m_hist [4];
  int           m_age  [4];
  int           m_rst_cnt = 0;

  task automatic model_clear();
    m_s1 = 4'hF; m_s2 = 4'hF; m_db = 4'h0; m_done = 4'h0;
    m_en = 4'h0; m_opt = 4'h0; m_evt = 1'b0; m_all_prev = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_hist[i] = '0;
      m_age[i]  = 0;
    end
  endtask

  task automatic model_tick();
    logic [3:0] sh, lg, set, new_db;
    logic       all, panic, found;
    if (!rst_n) begin
      model_clear();
      m_rst_cnt = 0;
      return;
    end
    if (m_rst_cnt < 2) begin
      m_rst_cnt++;
      return;
    end
    all   = &m_db;
    panic = all & ~m_all_prev;
    sh    = 4'h0;
    lg    = 4'h0;
    for (int i = 0; i < 4; i++) begin
      if (!all && !m_done[i]) begin
        if (m_db[i] && m_age[i] == L + 1) lg[i] = 1'b1;
        if (!m_db[i] && m_age[i] > 0 && m_age[i] < L) sh[i] = 1'b1;
      end
    end
    if (panic) begin
      m_en = 4'h0; m_opt = 4'h0; m_evt = 1'b1;
    end else begin
`ifdef PEDAL_CTRL_EXCLUSIVE_FX_EN
      set   = sh & ~m_en;
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (set[k] && !found) begin
          m_en  = 4'b0001 << k;
          found = 1'b1;
        end
      end
      if (!found) m_en = m_en & ~sh;
`else
      set   = 4'h0;
      found = 1'b0;
      m_en  = m_en ^ sh;
`endif
      m_opt = m_opt ^ lg;
      m_evt = |{sh, lg};
    end
    for (int i = 0; i < 4; i++) begin
      if (all || lg[i]) m_done[i] = 1'b1;
      else if (!m_db[i] && m_age[i] > 0) m_done[i] = 1'b0;
    end
    m_all_prev = all;
    new_db = m_db;
    for (int i = 0; i < 4; i++) begin
      m_hist[i] = {m_hist[i][D-2:0], ~m_s2[i]};
      if (!m_db[i] && (&m_hist[i])) new_db[i] = 1'b1;
      if (m_db[i] && m_hist[i] == '0) new_db[i] = 1'b0;
      if (new_db[i]) m_age[i] = m_db[i] ? m_age[i] + 1 : 1;
      else           m_age[i] = m_db[i] ? m_age[i] : 0;
    end
    m_db = new_db;
    m_s2 = m_s1;
    m_s1 = fsw_n;
  endtask

  always @(posedge clk_48) model_tick();

  task automatic do_reset();
    rst_n = 1'b0;
    fsw_n = 4'hF;
    repeat (3) @(negedge clk_48);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_48);
  endtask

  task automatic test_reset();
    int n_evt = 0;
    int lat = -1;
    rst_n = 1'b0;
    fsw_n = 4'b1011;
    repeat (3) @(negedge clk_48);
    checks++;
    if ({en, options, led, evt} !== 13'h0) begin
      errors++;
      $display("FAIL reset_outputs: en=%b options=%b led=%b evt=%b, required all zero", en, options, led, evt);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_48);
      if (evt) n_evt++;
    end
    checks++;
    if (n_evt != 0 || en !== 4'h0 || options !== 4'h0) begin
      errors++;
      $display("FAIL reset_held_press: evts=%0d en=%b options=%b, required 0/0000/0000", n_evt, en, options);
    end
    fsw_n = 4'hF;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk_48);
      if (evt && lat < 0) lat = c;
    end
    checks++;
    if (lat != 2 + D + 1 || en !== 4'b0100 || options !== 4'h0) begin
      errors++;
      $display("FAIL reset_release_short: latency=%0d en=%b options=%b, required %0d/0100/0000", lat, en, options, 2 + D + 1);
    end
  endtask

  task automatic test_short_press();
    int n_evt = 0;
    int lat = -1;
    do_reset();
    fsw_n = 4'b1011;
    repeat (10) @(negedge clk_48);
    fsw_n = 4'hF;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk_48);
      if (evt) begin
        n_evt++;
        if (lat < 0) lat = c;
      end
    end
    checks++;
    if (n_evt != 1 || lat != 2 + D + 1 || en !== 4'b0100 || led !== 4'b0100 || options !== 4'h0) begin
      errors++;
      $display("FAIL short_on: evts=%0d latency=%0d en=%b led=%b options=%b, required 1/%0d/0100/0100/0000", n_evt, lat, en, led, options, 2 + D + 1);
    end
    n_evt = 0;
    fsw_n = 4'b1011;
    repeat (10) @(negedge clk_48);
    fsw_n = 4'hF;
    repeat (15) begin
      @(negedge clk_48);
      if (evt) n_evt++;
    end
    checks++;
    if (n_evt != 1 || en !== 4'h0 || led !== 4'h0) begin
      errors++;
      $display("FAIL short_off: evts=%0d en=%b led=%b, required 1/0000/0000", n_evt, en, led);
    end
  endtask

  task automatic test_bounce();
    int n_evt = 0;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      fsw_n = {3'b111, c[1]};
      @(negedge clk_48);
      if (evt) n_evt++;
    end
    fsw_n = 4'hF;
    repeat (15) begin
      @(negedge clk_48);
      if (evt) n_evt++;
    end
    checks++;
    if (n_evt != 0 || en !== 4'h0 || options !== 4'h0) begin
      errors++;
      $display("FAIL bounce_toggle: evts=%0d en=%b options=%b, required 0/0000/0000", n_evt, en, options);
    end
    fsw_n = 4'b1110;
    repeat (D - 1) @(negedge clk_48);
    fsw_n = 4'hF;
    repeat (15) begin
      @(negedge clk_48);
      if (evt) n_evt++;
    end
    checks++;
    if (n_evt != 0 || en !== 4'h0) begin
      errors++;
      $display("FAIL glitch_below_debounce: evts=%0d en=%b, required 0/0000", n_evt, en);
    end
    fsw_n = 4'b1110;
    repeat (D) @(negedge clk_48);
    fsw_n = 4'hF;
    repeat (15) begin
      @(negedge clk_48);
      if (evt) n_evt++;
    end
    checks++;
    if (n_evt != 1 || en !== 4'b0001) begin
      errors++;
      $display("FAIL pulse_at_debounce: evts=%0d en=%b, required 1/0001", n_evt, en);
    end
  endtask

  task automatic test_long_press();
    int n_evt = 0;
    int lat = -1;
    do_reset();
    fsw_n = 4'b0111;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk_48);
      if (evt) begin
        n_evt++;
        if (lat < 0) lat = c;
      end
    end
    checks++;
    if (n_evt != 1 || lat != 2 + D + L + 1 || options !== 4'b1000 || en !== 4'h0) begin
      errors++;
      $display("FAIL long_press: evts=%0d latency=%0d options=%b en=%b, required 1/%0d/1000/0000", n_evt, lat, options, en, 2 + D + L + 1);
    end
    n_evt = 0;
    fsw_n = 4'hF;
    repeat (15) begin
      @(negedge clk_48);
      if (evt) n_evt++;
    end
    checks++;
    if (n_evt != 0 || en !== 4'h0 || options !== 4'b1000) begin
      errors++;
      $display("FAIL long_release: evts=%0d en=%b options=%b, required 0/0000/1000", n_evt, en, options);
    end
  endtask

  task automatic test_simultaneous_panic();
    int n_evt = 0;
    do_reset();
    fsw_n = 4'b1100;
    repeat (10) @(negedge clk_48);
    fsw_n = 4'hF;
    repeat (15) begin
      @(negedge clk_48);
      if (evt) n_evt++;
    end
    checks++;
    if (n_evt != 1 || en !== 4'b0011) begin
      errors++;
      $display("FAIL simultaneous_short: evts=%0d en=%b, required 1/0011", n_evt, en);
    end
    n_evt = 0;
    fsw_n = 4'h0;
    repeat (10) begin
      @(negedge clk_48);
      if (evt) n_evt++;
    end
    checks++;
    if (n_evt != 1 || en !== 4'h0 || options !== 4'h0) begin
      errors++;
      $display("FAIL panic: evts=%0d en=%b options=%b, required 1/0000/0000", n_evt, en, options);
    end
    n_evt = 0;
    fsw_n = 4'hF;
    repeat (15) begin
      @(negedge clk_48);
      if (evt) n_evt++;
    end
    checks++;
    if (n_evt != 0 || en !== 4'h0 || options !== 4'h0) begin
      errors++;
      $display("FAIL panic_release: evts=%0d en=%b options=%b, required 0/0000/0000", n_evt, en, options);
    end
  endtask

  task automatic test_exclusive();
    logic [3:0] exp_second;
`ifdef PEDAL_CTRL_EXCLUSIVE_FX_EN
    exp_second = 4'b0100;
`else
    exp_second = 4'b0110;
`endif
    do_reset();
    fsw_n = 4'b1101;
    repeat (10) @(negedge clk_48);
    fsw_n = 4'hF;
    repeat (15) @(negedge clk_48);
    checks++;
    if (en !== 4'b0010) begin
      errors++;
      $display("FAIL exclusive_first: en=%b, required 0010", en);
    end
    fsw_n = 4'b1011;
    repeat (10) @(negedge clk_48);
    fsw_n = 4'hF;
    repeat (15) @(negedge clk_48);
    checks++;
    if (en !== exp_second) begin
      errors++;
      $display("FAIL exclusive_second: en=%b, required %b", en, exp_second);
    end
  endtask

  task automatic test_random();
    int         st [4];
    int         dur[4];
    int         len, rst_at;
    logic [3:0] mask, gl, raw;
    do_reset();
    for (int ep = 0; ep < 40; ep++) begin
      mask = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 5) == 0) mask = 4'hF;
      gl  = 4'($urandom_range(0, 15));
      len = 0;
      for (int i = 0; i < 4; i++) begin
        st[i]  = int'($urandom_range(0, 3));
        dur[i] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(5, 14)) : int'($urandom_range(26, 40));
        if (st[i] + dur[i] > len) len = st[i] + dur[i];
      end
      rst_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 20)) : -10;
      for (int c = 0; c < len + 20; c++) begin
        for (int i = 0; i < 4; i++)
          raw[i] = !(mask[i] && c >= st[i] && c < st[i] + dur[i] && !(gl[i] && c == st[i] + 1));
        fsw_n = raw;
        rst_n = (c == rst_at || c == rst_at + 1) ? 1'b0 : 1'b1;
        @(negedge clk_48);
        checks++;
        if ({en, options, led, evt} !== {m_en, m_opt, m_en, m_evt}) begin
          errors++;
          $display("FAIL random ep%0d cyc%0d: en=%b options=%b led=%b evt=%b, required en=%b options=%b led=%b evt=%b",
                   ep, c, en, options, led, evt, m_en, m_opt, m_en, m_evt);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    fsw_n = 4'b1011;
    test_reset();
    test_short_press();
    test_bounce();
    test_long_press();
    test_simultaneous_panic();
    test_exclusive();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
